// File: rtl/ir_packet_scheduler_pkg.sv
// Shared definitions for the IR packet scheduler: FSM encoding, car indices,
// bus register offsets and the status byte layout.
package ir_packet_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARB  = 2'd1,
    ST_SEND = 2'd2,
    ST_WAIT = 2'd3
  } state_e;

  localparam logic [1:0] CAR_BLUE   = 2'd0;
  localparam logic [1:0] CAR_YELLOW = 2'd1;
  localparam logic [1:0] CAR_GREEN  = 2'd2;
  localparam logic [1:0] CAR_RED    = 2'd3;

  localparam logic [7:0] OFF_CMD0   = 8'd0;
  localparam logic [7:0] OFF_CMD1   = 8'd1;
  localparam logic [7:0] OFF_CMD2   = 8'd2;
  localparam logic [7:0] OFF_CMD3   = 8'd3;
  localparam logic [7:0] OFF_ENABLE = 8'd4;
  localparam logic [7:0] OFF_STATUS = 8'd5;

  function automatic logic [7:0] status_byte(input logic busy, input logic [1:0] last,
                                             input logic [3:0] pend);
    return {busy, last, 1'b0, pend};
  endfunction

endpackage

// File: rtl/ir_packet_scheduler_rr_arbiter4.sv
// Four-way round-robin pick: the first set request strictly after 'last',
// wrapping around so that 'last' itself is considered least recently eligible.
module rr_arbiter4 (
  input  logic [3:0] req_i,
  input  logic [1:0] last_i,
  output logic [1:0] grant_o,
  output logic       valid_o
);

  logic [1:0] idx_s;

  // Walk from farthest to nearest so the nearest requester overwrites the rest.
  always_comb begin
    grant_o = last_i;
    valid_o = 1'b0;
    idx_s   = 2'd0;
    for (int k = 4; k >= 1; k--) begin
      idx_s = last_i + 2'(k);
      if (req_i[idx_s]) begin
        grant_o = idx_s;
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ir_packet_scheduler.sv
// Bus-programmed scheduler that hands one IR packet per slot to the transmitter,
// rotating fairly among four cars and enforcing a fixed strobe-to-strobe gap.
module ir_packet_scheduler
  import ir_packet_scheduler_pkg::*;
#(
  parameter logic [7:0] BaseAddr  = 8'hA0,
  parameter int         GapCycles = 10_000_000
) (
  input  logic       CLK,
  input  logic       RESET,
  inout  wire  [7:0] BUS_DATA,
  input  logic [7:0] BUS_ADDR,
  input  logic       BUS_WE,
  output logic       TX_SEND,
  output logic [3:0] TX_COMMAND,
  output logic [1:0] TX_CAR,
  output logic       BUSY
);

  localparam int              CntW    = $clog2(GapCycles);
  localparam logic [CntW-1:0] CntLast = CntW'(GapCycles - 4);

  state_e          state_q;
  logic [3:0]      cmd_q [4];
  logic [3:0]      pend_q, pend_d, pend_clr_s;
  logic [3:0]      enable_q;
  logic [1:0]      last_q;
  logic [CntW-1:0] cnt_q;
  logic [3:0]      cmd_wr_s;
  logic            en_wr_s;
  logic            status_rd_s;
  logic [1:0]      arb_grant_s;
  logic            arb_valid_s;

  rr_arbiter4 u_arb (
    .req_i   (pend_q),
    .last_i  (last_q),
    .grant_o (arb_grant_s),
    .valid_o (arb_valid_s)
  );

  // Address decode for the write-only registers; the status offset is read-only.
  always_comb begin
    cmd_wr_s = 4'b0000;
    en_wr_s  = 1'b0;
    if (BUS_WE) begin
      for (int k = 0; k < 4; k++) begin
        if (BUS_ADDR == BaseAddr + OFF_CMD0 + 8'(k)) cmd_wr_s[k] = 1'b1;
      end
      if (BUS_ADDR == BaseAddr + OFF_ENABLE) en_wr_s = 1'b1;
    end
  end

  assign status_rd_s = !BUS_WE && (BUS_ADDR == BaseAddr + OFF_STATUS);
  assign BUS_DATA    = status_rd_s ? status_byte(BUSY, last_q, pend_q) : 8'bzzzz_zzzz;

  // A fresh command write re-arms its car even when arbitration clears it this cycle.
  always_comb begin
    pend_clr_s = 4'b0000;
    if (state_q == ST_ARB && arb_valid_s && !enable_q[arb_grant_s]) begin
      pend_clr_s[arb_grant_s] = 1'b1;
    end
    pend_d = (pend_q & ~pend_clr_s) | cmd_wr_s;
  end

  // Register file, slot FSM and transmitter-facing outputs.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q    <= ST_IDLE;
      for (int k = 0; k < 4; k++) cmd_q[k] <= 4'h0;
      pend_q     <= 4'b0000;
      enable_q   <= 4'b0000;
      last_q     <= CAR_RED;
      cnt_q      <= '0;
      TX_SEND    <= 1'b0;
      TX_COMMAND <= 4'h0;
      TX_CAR     <= CAR_BLUE;
      BUSY       <= 1'b0;
    end else begin
      pend_q <= pend_d;
      for (int k = 0; k < 4; k++) begin
        if (cmd_wr_s[k]) cmd_q[k] <= BUS_DATA[3:0];
      end
      if (en_wr_s) enable_q <= BUS_DATA[3:0];
      case (state_q)
        ST_IDLE: begin
          if (|pend_q) state_q <= ST_ARB;
        end
        ST_ARB: begin
          if (arb_valid_s) begin
            TX_CAR     <= arb_grant_s;
            TX_COMMAND <= cmd_q[arb_grant_s];
            last_q     <= arb_grant_s;
            TX_SEND    <= 1'b1;
            BUSY       <= 1'b1;
            state_q    <= ST_SEND;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_SEND: begin
          TX_SEND <= 1'b0;
          cnt_q   <= '0;
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          // Leaving here after GapCycles-3 wait cycles makes IDLE+ARB+SEND close the gap.
          if (cnt_q == CntLast) begin
            BUSY    <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ir_packet_scheduler.sv
// Self-checking bench: directed scenarios plus random bus traffic, all compared
// against a slot-level reference model of the scheduler.
module tb_ir_packet_scheduler;

  localparam int         G  = 8;
  localparam logic [7:0] BA = 8'hA0;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  wire  [7:0] bus_data;
  logic [7:0] bus_addr = 8'h00;
  logic [7:0] tb_drv = 8'h00;
  logic       bus_we = 1'b0;
  logic       tb_oe = 1'b0;
  logic       tx_send;
  logic [3:0] tx_cmd;
  logic [1:0] tx_car;
  logic       busy;

  assign bus_data = tb_oe ? tb_drv : 8'bzzzz_zzzz;

  ir_packet_scheduler #(.BaseAddr(BA), .GapCycles(G)) dut (
    .CLK        (clk),
    .RESET      (rst_n),
    .BUS_DATA   (bus_data),
    .BUS_ADDR   (bus_addr),
    .BUS_WE     (bus_we),
    .TX_SEND    (tx_send),
    .TX_COMMAND (tx_cmd),
    .TX_CAR     (tx_car),
    .BUSY       (busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int t_free = 0;
  logic [3:0] m_pend = 4'h0;
  logic [3:0] m_en = 4'h0;
  logic [3:0] pend_hist = 4'h0;
  logic [3:0] m_cmd [4];
  logic [1:0] m_last = 2'd3;
  logic [1:0] e_car = 2'd0;
  logic [3:0] e_cmd = 4'h0;
  logic       e_busy = 1'b0;
  int q_cyc[$];
  int q_car[$];
  int q_cmd[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock: drive at negedge, sample 1 time unit after posedge, advance model, compare.
  task automatic step(input logic rst, input int op, input logic [7:0] addr, input logic [7:0] data);
    logic [3:0] pre;
    logic       exp_strobe;
    int         w;
    int         ai;
    @(negedge clk);
    rst_n    = rst;
    bus_we   = (op == 1);
    tb_oe    = (op == 1);
    bus_addr = addr;
    tb_drv   = data;
    @(posedge clk);
    #1;
    cyc++;
    exp_strobe = 1'b0;
    if (!rst) begin
      m_pend = 4'h0; m_en = 4'h0; m_last = 2'd3; t_free = 0; pend_hist = 4'h0;
      for (int k = 0; k < 4; k++) m_cmd[k] = 4'h0;
      e_car = 2'd0; e_cmd = 4'h0;
    end else begin
      pre = m_pend;
      // Scheduler is free once the gap has elapsed; it launches two cycles after seeing work.
      exp_strobe = (cyc >= t_free) && (pend_hist != 4'h0);
      if (exp_strobe) begin
        w = -1;
        for (int k = 1; k <= 4; k++) begin
          int idx;
          idx = (int'(m_last) + k) % 4;
          if (w < 0 && m_pend[idx]) w = idx;
        end
        if (w >= 0) begin
          e_car  = w[1:0];
          e_cmd  = m_cmd[w];
          m_last = w[1:0];
          if (!m_en[w]) m_pend[w] = 1'b0;
          t_free = cyc + G;
          q_cyc.push_back(cyc); q_car.push_back(w); q_cmd.push_back(int'(e_cmd));
        end
      end
      if (op == 1) begin
        ai = int'(addr) - int'(BA);
        if (ai >= 0 && ai < 4) begin
          m_cmd[ai]  = data[3:0];
          m_pend[ai] = 1'b1;
        end else if (ai == 4) begin
          m_en = data[3:0];
        end
      end
      pend_hist = pre;
    end
    e_busy = rst && (cyc < t_free - 2);
    chk("tx_send", 32'(tx_send), 32'(exp_strobe));
    chk("tx_car", 32'(tx_car), 32'(e_car));
    chk("tx_command", 32'(tx_cmd), 32'(e_cmd));
    chk("busy", 32'(busy), 32'(e_busy));
    if (op == 2 && addr == BA + 8'd5)
      chk("status", 32'(bus_data), 32'({e_busy, m_last, 1'b0, m_pend}));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 0, 8'h00, 8'h00);
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    step(1'b1, 1, a, d);
  endtask

  task automatic rd();
    step(1'b1, 2, BA + 8'd5, 8'h00);
  endtask

  initial begin
    int base;
    int base2;
    int wcyc;
    int r;

    for (int k = 0; k < 4; k++) m_cmd[k] = 4'h0;

    // Reset state
    repeat (3) step(1'b0, 0, 8'h00, 8'h00);
    rd();
    chk("reset_status", 32'(bus_data), 32'h60);

    // Single write to green: one strobe two cycles later, then quiet
    base = q_cyc.size();
    wr(BA + 8'd2, 8'h05);
    wcyc = cyc;
    idle(12);
    chk("single_count", 32'(q_cyc.size() - base), 32'd1);
    if (q_cyc.size() > base) begin
      chk("single_car", 32'(q_car[base]), 32'd2);
      chk("single_cmd", 32'(q_cmd[base]), 32'd5);
      chk("single_latency", 32'(q_cyc[base] - wcyc), 32'd2);
    end
    rd();
    chk("single_pend", 32'(bus_data[3:0]), 32'd0);

    // Three cars queued back to back: order 0,1,3 with exact spacing
    base = q_cyc.size();
    wr(BA + 8'd0, 8'h01);
    wr(BA + 8'd1, 8'h02);
    wr(BA + 8'd3, 8'h03);
    idle(30);
    chk("queue_count", 32'(q_cyc.size() - base), 32'd3);
    if (q_cyc.size() >= base + 3) begin
      chk("queue_car0", 32'(q_car[base]), 32'd0);
      chk("queue_car1", 32'(q_car[base + 1]), 32'd1);
      chk("queue_car2", 32'(q_car[base + 2]), 32'd3);
      chk("queue_gap0", 32'(q_cyc[base + 1] - q_cyc[base]), 32'(G));
      chk("queue_gap1", 32'(q_cyc[base + 2] - q_cyc[base + 1]), 32'(G));
    end

    // Repeat mode on cars 0 and 1, then drain after disabling
    base = q_cyc.size();
    wr(BA + 8'd4, 8'h03);
    wr(BA + 8'd0, 8'h01);
    wr(BA + 8'd1, 8'h02);
    idle(40);
    chk("repeat_many", 32'((q_cyc.size() - base) >= 4), 32'd1);
    for (int i = base + 1; i < q_cyc.size(); i++) begin
      chk("repeat_alt", 32'(q_car[i] != q_car[i - 1]), 32'd1);
      chk("repeat_gap", 32'(q_cyc[i] - q_cyc[i - 1]), 32'(G));
    end
    wr(BA + 8'd4, 8'h00);
    base2 = q_cyc.size();
    idle(30);
    chk("repeat_tail", 32'((q_cyc.size() - base2) <= 2), 32'd1);
    base2 = q_cyc.size();
    idle(20);
    chk("repeat_stopped", 32'(q_cyc.size() - base2), 32'd0);

    // Command rewrite for the car in flight
    base = q_cyc.size();
    wr(BA + 8'd1, 8'h03);
    idle(3);
    wr(BA + 8'd1, 8'h09);
    chk("inflight_hold", 32'(tx_cmd), 32'h3);
    idle(14);
    chk("inflight_count", 32'(q_cyc.size() - base), 32'd2);
    if (q_cyc.size() >= base + 2) begin
      chk("inflight_old", 32'(q_cmd[base]), 32'h3);
      chk("inflight_new", 32'(q_cmd[base + 1]), 32'h9);
      chk("inflight_car", 32'(q_car[base + 1]), 32'd1);
    end

    // Reset in the middle of a wait slot
    wr(BA + 8'd4, 8'h01);
    wr(BA + 8'd0, 8'h07);
    idle(5);
    step(1'b0, 0, 8'h00, 8'h00);
    chk("midreset_busy", 32'(busy), 32'd0);
    chk("midreset_car", 32'(tx_car), 32'd0);
    chk("midreset_cmd", 32'(tx_cmd), 32'd0);
    rd();
    chk("midreset_status", 32'(bus_data), 32'h60);
    base = q_cyc.size();
    idle(20);
    chk("midreset_quiet", 32'(q_cyc.size() - base), 32'd0);

    // Random bus traffic against the model
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 199);
      if (r < 2)        step(1'b0, 0, 8'h00, 8'h00);
      else if (r < 110) idle(1);
      else if (r < 160) wr(BA + 8'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
      else if (r < 168) wr(BA + 8'd4, 8'($urandom_range(0, 15)));
      else if (r < 188) rd();
      else if (r < 194) wr(BA + 8'd5, 8'($urandom_range(0, 255)));
      else              wr(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ir_packet_scheduler.md
IR_PACKET_SCHEDULER -- requirements
Module: ir_packet_scheduler

Interface
REQ-001 SHALL have parameter BaseAddr, default 8'hA0; base of this block's 6-register bus window.
REQ-002 SHALL have parameter GapCycles, default 10_000_000; CLK cycles from one transmit strobe to earliest next strobe (100 ms at 100 MHz).
REQ-003 SHALL have port CLK  input  1  system clock; all logic on rising edge; one clock only.
REQ-004 SHALL have port RESET  input  1  synchronous, active-low reset (0 = reset).
REQ-005 SHALL have port BUS_DATA  inout  8  shared data bus; driven only during status read, else high-Z.
REQ-006 SHALL have port BUS_ADDR  input  8  shared address bus.
REQ-007 SHALL have port BUS_WE  input  1  bus write enable.
REQ-008 SHALL have port TX_SEND  output  1  one-cycle strobe to the IR transmitter's send input.
REQ-009 SHALL have port TX_COMMAND  output  4  command nibble for the transmitter.
REQ-010 SHALL have port TX_CAR  output  2  car select: 0 blue, 1 yellow, 2 green, 3 red.
REQ-011 SHALL have port BUSY  output  1  high while a packet slot (SEND or WAIT) is in progress.

Function
REQ-012 SHALL decode BaseAddr+0..+3 as write-only CMD[n] for car n; a write latches BUS_DATA[3:0] into CMD[n] and sets PEND[n].
REQ-013 SHALL decode BaseAddr+4 as write-only ENABLE mask (BUS_DATA[3:0]); ENABLE[n]=1 selects repeat mode for car n.
REQ-014 SHALL decode BaseAddr+5 as read-only STATUS = {BUSY, LAST[1:0], 1'b0, PEND[3:0]}, driven combinationally onto BUS_DATA when BUS_ADDR matches and BUS_WE=0.
REQ-015 SHALL ignore writes to BaseAddr+5 and all addresses outside the window.
REQ-016 SHALL implement FSM states IDLE, ARB, SEND, WAIT.
REQ-017 IDLE -> ARB when any PEND bit is set; else remain IDLE.
REQ-018 ARB SHALL pick the first set PEND bit searching round-robin from LAST+1 (mod 4), load TX_CAR and TX_COMMAND from it, update LAST, and go to SEND; ARB lasts exactly one cycle.
REQ-019 In ARB, PEND[winner] SHALL be cleared unless ENABLE[winner]=1, in which case it stays set.
REQ-020 SEND SHALL assert TX_SEND for exactly one cycle, then go to WAIT with the gap counter at zero.
REQ-021 WAIT SHALL count to GapCycles-3 (so strobe-to-strobe spacing is exactly GapCycles when work is continuously pending) and then return to IDLE.
REQ-022 TX_CAR and TX_COMMAND SHALL be held stable from ARB through the end of WAIT; they change only in ARB.
REQ-023 BUSY SHALL be 1 in SEND and WAIT, 0 in IDLE and ARB.
REQ-024 A CMD[n] write in the same cycle that ARB clears PEND[n] SHALL leave PEND[n] set (write wins) and CMD[n] updated; the packet in flight keeps the old command.
REQ-025 A CMD[n] write during SEND/WAIT for the car in flight SHALL not alter TX_COMMAND.
REQ-026 Clearing ENABLE[n] SHALL not clear PEND[n]; car n then receives one more packet.
REQ-027 Gap counter SHALL be sized ceil(log2(GapCycles)) bits; GapCycles >= 4 is required.

Reset
REQ-028 While RESET=0 at a clock edge: state IDLE, CMD[*]=0, PEND=0, ENABLE=0, LAST=3 (so car 0 wins first), counter 0, TX_SEND=0, TX_COMMAND=0, TX_CAR=0, BUSY=0.
REQ-029 Reset asserted mid-SEND or mid-WAIT SHALL abort the slot within the same edge; no further TX_SEND until new writes after release.

Structure
REQ-030 Shared package SHALL hold FSM state encoding, car index constants (BLUE=0, YELLOW=1, GREEN=2, RED=3) and register offsets (+0..+5).
REQ-031 Round-robin arbiter SHALL be a separate sub-module rr_arbiter4 (inputs req[3:0], last[1:0]; outputs grant index, valid); rest stays in ir_packet_scheduler.

Verification (GapCycles=8 on bench)
REQ-032 Reset release, write 0x5 to BaseAddr+2 -> one TX_SEND with TX_CAR=2, TX_COMMAND=5, 2 cycles after write; PEND=0 afterwards; no further strobe.
REQ-033 Write cars 0,1,3 in consecutive cycles while idle -> strobes in order car 0,1,3, spaced exactly 8 cycles.
REQ-034 ENABLE=4'b0011, CMD[0]=0x1, CMD[1]=0x2 -> strobes alternate car0/car1 every 8 cycles indefinitely; clear ENABLE -> each car sent at most once more, then idle.
REQ-035 Write CMD[1]=0x9 during WAIT of a car-1 packet -> TX_COMMAND stays old value until next ARB; next car-1 packet carries 0x9.
REQ-036 Assert RESET=0 in mid-WAIT -> next edge BUSY=0, TX_* = 0, STATUS reads 0x60 (LAST=3) after release; no strobe until a new write.
